// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), coordinate/colour types
// and a window helper used by the sync comparators.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam bit SYNC_ACT  = 1'b0;

   localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_VISIBLE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_VISIBLE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef logic [9:0] coord_t;
   typedef logic [7:0] chan_t;

   typedef struct packed {
      chan_t r;
      chan_t g;
      chan_t b;
   } rgb_t;

   function automatic logic in_window(coord_t v, int lo, int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator bundle: pixel strobe and mapper colour in, draw coordinates,
// VGA pins and game ticks out. master = scan generator, slave = its consumer.
interface vga_scan_gen_if;
   import vga_timing_pkg::*;

   logic   pix_en;
   chan_t  R_in;
   chan_t  G_in;
   chan_t  B_in;
   coord_t DrawX;
   coord_t DrawY;
   chan_t  VGA_R;
   chan_t  VGA_G;
   chan_t  VGA_B;
   logic   VGA_HS;
   logic   VGA_VS;
   logic   VGA_BLANK_N;
   logic   line_start;
   logic   frame_start;

   modport master (
      input  pix_en, R_in, G_in, B_in,
      output DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
             line_start, frame_start
   );

   modport slave (
      output pix_en, R_in, G_in, B_in,
      input  DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
             line_start, frame_start
   );

endinterface

// File: rtl/vga_scan_gen_counter.sv
// Modulo-MAX counter with enable. wrap flags the terminal count so the caller
// can chain the next counter; out-of-range values also wrap to 0.
module scan_counter #(
   parameter int MAX = 800,
   parameter int W   = 10
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = (count >= W'(MAX - 1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (en)
         count <= wrap ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: DrawX/DrawY are the live counters; colour, blank and
// syncs are registered one pixel later so they line up with the mapper's RGB.
module vga_scan_gen #(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP,
   parameter bit SYNC_ACT  = vga_timing_pkg::SYNC_ACT
) (
   input  logic          Clk,
   input  logic          Reset,
   vga_scan_gen_if.master bus
);
   import vga_timing_pkg::*;

   localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS0 = H_VISIBLE + H_FP;
   localparam int HS1 = HS0 + H_SYNC - 1;
   localparam int VS0 = V_VISIBLE + V_FP;
   localparam int VS1 = VS0 + V_SYNC - 1;

   coord_t hc, vc;
   logic   h_last, v_last;
   logic   vis, hs_win, vs_win;
   rgb_t   pix_q;
   logic   blank_n_q, hs_q, vs_q, line_q, frame_q;

   scan_counter #(.MAX(HT), .W(10)) u_hc (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (bus.pix_en),
      .count (hc),
      .wrap  (h_last)
   );

   scan_counter #(.MAX(VT), .W(10)) u_vc (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (bus.pix_en & h_last),
      .count (vc),
      .wrap  (v_last)
   );

   assign bus.DrawX = hc;
   assign bus.DrawY = vc;

   always_comb begin
      vis    = (hc < coord_t'(H_VISIBLE)) && (vc < coord_t'(V_VISIBLE));
      hs_win = in_window(hc, HS0, HS1);
      vs_win = in_window(vc, VS0, VS1);
   end

   // Ticks are sampled every Clk so they drop after one cycle even with pix_en low.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pix_q     <= '0;
         blank_n_q <= 1'b0;
         hs_q      <= !SYNC_ACT;
         vs_q      <= !SYNC_ACT;
         line_q    <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         line_q  <= bus.pix_en & h_last;
         frame_q <= bus.pix_en & h_last & v_last;
         if (bus.pix_en) begin
            blank_n_q <= vis;
            pix_q     <= vis ? rgb_t'{bus.R_in, bus.G_in, bus.B_in} : '0;
            hs_q      <= hs_win ? SYNC_ACT : !SYNC_ACT;
            vs_q      <= vs_win ? SYNC_ACT : !SYNC_ACT;
         end
      end
   end

   assign bus.VGA_R       = pix_q.r;
   assign bus.VGA_G       = pix_q.g;
   assign bus.VGA_B       = pix_q.b;
   assign bus.VGA_BLANK_N = blank_n_q;
   assign bus.VGA_HS      = hs_q;
   assign bus.VGA_VS      = vs_q;
   assign bus.line_start  = line_q;
   assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default-timing instance plus a tiny-timing,
// active-high-sync instance so whole frames fit in a short run.
module tb_vga_scan_gen;
   import vga_timing_pkg::*;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb;
      bit act;
   } tim_t;

   typedef struct {
      int   n;
      logic [7:0] r, g, b;
      logic blank, hs, vs, ls, fs;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #10 Clk = ~Clk;

   vga_scan_gen_if bus ();
   vga_scan_gen_if sbus ();

   vga_scan_gen dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   vga_scan_gen #(
      .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_VISIBLE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_ACT(1'b1)
   ) dut_s (.Clk(Clk), .Reset(Reset), .bus(sbus));

   int checks = 0;
   int errors = 0;
   tim_t tb_t, ts_t;
   exp_t eb, es;
   int hs_low, ls_cnt, s_vs_act, s_hs_act, s_fs_cnt;

   function automatic int htot(tim_t t); return t.hv + t.hf + t.hs + t.hb; endfunction
   function automatic int vtot(tim_t t); return t.vv + t.vf + t.vs + t.vb; endfunction

   function automatic exp_t reset_exp(tim_t t);
      exp_t o;
      o.n = 0; o.r = 0; o.g = 0; o.b = 0;
      o.blank = 0; o.hs = !t.act; o.vs = !t.act; o.ls = 0; o.fs = 0;
      return o;
   endfunction

   // Position is just the strobe count since reset, folded into line/frame.
   function automatic exp_t step_exp(tim_t t, exp_t e, logic pe, logic [7:0] r, g, b);
      exp_t o = e;
      int x = e.n % htot(t);
      int y = e.n / htot(t);
      bit vis;
      o.ls = 0; o.fs = 0;
      if (pe) begin
         vis     = (x < t.hv) && (y < t.vv);
         o.blank = vis;
         o.r     = vis ? r : 8'd0;
         o.g     = vis ? g : 8'd0;
         o.b     = vis ? b : 8'd0;
         o.hs    = (x >= t.hv + t.hf && x < t.hv + t.hf + t.hs) ? t.act : !t.act;
         o.vs    = (y >= t.vv + t.vf && y < t.vv + t.vf + t.vs) ? t.act : !t.act;
         o.n     = (e.n + 1) % (htot(t) * vtot(t));
         o.ls    = (o.n % htot(t)) == 0;
         o.fs    = (o.n == 0);
      end
      return o;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic cmp_big;
      chk("b_x", 32'(bus.DrawX), eb.n % htot(tb_t));
      chk("b_y", 32'(bus.DrawY), eb.n / htot(tb_t));
      chk("b_r", 32'(bus.VGA_R), 32'(eb.r));
      chk("b_g", 32'(bus.VGA_G), 32'(eb.g));
      chk("b_b", 32'(bus.VGA_B), 32'(eb.b));
      chk("b_blank", 32'(bus.VGA_BLANK_N), 32'(eb.blank));
      chk("b_hs", 32'(bus.VGA_HS), 32'(eb.hs));
      chk("b_vs", 32'(bus.VGA_VS), 32'(eb.vs));
      chk("b_ls", 32'(bus.line_start), 32'(eb.ls));
      chk("b_fs", 32'(bus.frame_start), 32'(eb.fs));
   endtask

   task automatic cmp_small;
      chk("s_x", 32'(sbus.DrawX), es.n % htot(ts_t));
      chk("s_y", 32'(sbus.DrawY), es.n / htot(ts_t));
      chk("s_r", 32'(sbus.VGA_R), 32'(es.r));
      chk("s_g", 32'(sbus.VGA_G), 32'(es.g));
      chk("s_b", 32'(sbus.VGA_B), 32'(es.b));
      chk("s_blank", 32'(sbus.VGA_BLANK_N), 32'(es.blank));
      chk("s_hs", 32'(sbus.VGA_HS), 32'(es.hs));
      chk("s_vs", 32'(sbus.VGA_VS), 32'(es.vs));
      chk("s_ls", 32'(sbus.line_start), 32'(es.ls));
      chk("s_fs", 32'(sbus.frame_start), 32'(es.fs));
   endtask

   // One Clk: drive at negedge, advance model at posedge, compare at next negedge.
   task automatic cyc(logic pe, logic rst, logic [7:0] r, g, b);
      Reset = rst;
      bus.pix_en = pe;  bus.R_in = r;  bus.G_in = g;  bus.B_in = b;
      sbus.pix_en = pe; sbus.R_in = r; sbus.G_in = g; sbus.B_in = b;
      @(posedge Clk);
      if (rst) begin
         eb = reset_exp(tb_t);
         es = reset_exp(ts_t);
      end else begin
         eb = step_exp(tb_t, eb, pe, r, g, b);
         es = step_exp(ts_t, es, pe, r, g, b);
      end
      @(negedge Clk);
      cmp_big();
      cmp_small();
      hs_low   += (bus.VGA_HS == 1'b0);
      ls_cnt   += bus.line_start;
      s_vs_act += (sbus.VGA_VS == 1'b1);
      s_hs_act += (sbus.VGA_HS == 1'b1);
      s_fs_cnt += sbus.frame_start;
   endtask

   task automatic rcyc(logic pe, logic rst);
      cyc(pe, rst, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic run_to_x(int target);
      for (int i = 0; i < 900 && int'(bus.DrawX) != target; i++) rcyc(1'b1, 1'b0);
      chk("reach_x", 32'(bus.DrawX), target);
   endtask

   task automatic clr_counts;
      hs_low = 0; ls_cnt = 0; s_vs_act = 0; s_hs_act = 0; s_fs_cnt = 0;
   endtask

   initial begin
      int saved_x;
      tb_t = '{H_VISIBLE, H_FP, H_SYNC, H_BP, V_VISIBLE, V_FP, V_SYNC, V_BP, SYNC_ACT};
      ts_t = '{20, 3, 5, 4, 6, 2, 2, 3, 1'b1};
      eb = reset_exp(tb_t);
      es = reset_exp(ts_t);
      clr_counts();
      @(negedge Clk);

      // Reset held with strobes running
      for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b1);
      chk("rst_x", 32'(bus.DrawX), 0);
      chk("rst_y", 32'(bus.DrawY), 0);
      chk("rst_hs", 32'(bus.VGA_HS), 1);
      chk("rst_vs", 32'(bus.VGA_VS), 1);
      chk("rst_blank", 32'(bus.VGA_BLANK_N), 0);
      chk("rst_r", 32'(bus.VGA_R), 0);
      chk("rst_s_hs", 32'(sbus.VGA_HS), 0);

      // Visible pixel at (5,3)
      for (int i = 0; i < 3 * 800 + 5; i++) rcyc(1'b1, 1'b0);
      chk("at5_x", 32'(bus.DrawX), 5);
      chk("at5_y", 32'(bus.DrawY), 3);
      cyc(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
      chk("vis_r", 32'(bus.VGA_R), 32'hFF);
      chk("vis_blank", 32'(bus.VGA_BLANK_N), 1);

      // Blanked pixel at hc=700
      run_to_x(700);
      cyc(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
      chk("blk_r", 32'(bus.VGA_R), 0);
      chk("blk_blank", 32'(bus.VGA_BLANK_N), 0);

      // One full line of strobes from hc=0
      run_to_x(0);
      clr_counts();
      for (int i = 0; i < 800; i++) rcyc(1'b1, 1'b0);
      chk("line_hs_low", hs_low, 96);
      chk("line_ls_cnt", ls_cnt, 1);
      chk("line_x_back", 32'(bus.DrawX), 0);

      // Full frame on the small-timing instance (32x13, active-high syncs)
      rcyc(1'b1, 1'b1);
      clr_counts();
      for (int i = 0; i < 32 * 13; i++) rcyc(1'b1, 1'b0);
      chk("frm_vs_act", s_vs_act, 2 * 32);
      chk("frm_hs_act", s_hs_act, 5 * 13);
      chk("frm_fs_cnt", s_fs_cnt, 1);
      chk("frm_x0", 32'(sbus.DrawX), 0);
      chk("frm_y0", 32'(sbus.DrawY), 0);

      // Randomised strobes, colours and rare resets
      for (int i = 0; i < 20000; i++)
         rcyc($urandom_range(0, 3) != 0, $urandom_range(0, 2999) == 0);

      // Hold for 10 Clk with pix_en low
      rcyc(1'b0, 1'b0);
      run_to_x(123);
      saved_x = eb.n % htot(tb_t);
      for (int i = 0; i < 10; i++) rcyc(1'b0, 1'b0);
      chk("hold_x", 32'(bus.DrawX), saved_x);

      // Reset mid-line: immediate return to origin, no tick
      run_to_x(300);
      rcyc(1'b1, 1'b1);
      chk("mid_rst_x", 32'(bus.DrawX), 0);
      chk("mid_rst_y", 32'(bus.DrawY), 0);
      chk("mid_rst_ls", 32'(bus.line_start), 0);
      chk("mid_rst_fs", 32'(bus.frame_start), 0);
      rcyc(1'b1, 1'b0);
      chk("post_rst_ls", 32'(bus.line_start), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
